// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle.
//
// Groups the raw button input with the debounced outputs so the debouncer and
// its user connect through a single port.
//   btn_in      : raw, asynchronous, bouncing button level (1 = pressed)
//   btn_level   : debounced button level
//   btn_press   : one-clock pulse on an accepted press
//   btn_release : one-clock pulse on an accepted release
//
// master : the side that owns the raw button and consumes the debounced result
// slave  : the debouncer itself
interface button_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer.
//
// Synchronizes a raw button level into clk, then accepts a level change only
// after the synchronized level has been steady for DEBOUNCE_CYCLES samples.
// btn_level is the enable for the downstream 500 ms refresh counter.
//
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous reset, active low
//   bus  : button_debouncer_if.slave (btn_in in; btn_level, btn_press,
//          btn_release out, all registered)
//
// Parameters:
//   DEBOUNCE_CYCLES : stable samples required to accept an edge (>= 2)
//   CNT_W           : counter width, must hold DEBOUNCE_CYCLES-1
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | accepted level 0, waiting for the synchronized input to go 1
// ARM_ON  | input went 1, counting stable 1 samples toward a press
// HIGH    | accepted level 1, waiting for the synchronized input to go 0
// ARM_OFF | input went 0, counting stable 0 samples toward a release
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                clk,
  input logic                rst,
  button_debouncer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_ON  = 2'd1,
    HIGH    = 2'd2,
    ARM_OFF = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             btn_s;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  assign btn_s = s2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) begin
          state_d = ARM_ON;
        end
      end

      ARM_ON: begin
        if (!btn_s) begin
          // glitch: back to the accepted level without a pulse
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HIGH: begin
        cnt_d = '0;
        if (!btn_s) begin
          state_d = ARM_OFF;
        end
      end

      ARM_OFF: begin
        if (btn_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= bus.btn_in;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4.
//
// Reference model: the debounced level flips once the input, seen two clocks
// late, has differed from the current level for D+1 consecutive edges; the
// flip emits the matching one-cycle pulse. Outputs are compared with the model
// on every falling edge, with literal timing checks for the directed cases.
module tb_button_debouncer;
  localparam int D = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_debouncer_if bus();

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] hist_m = 2'b00;   // input as seen 1 and 2 edges ago
  logic       seen_m = 1'b0;
  logic       lvl_m  = 1'b0;
  logic       prs_m  = 1'b0;
  logic       rel_m  = 1'b0;
  int         run_m  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_m = 2'b00;
      lvl_m  = 1'b0;
      prs_m  = 1'b0;
      rel_m  = 1'b0;
      run_m  = 0;
    end else begin
      seen_m = hist_m[1];
      hist_m = {hist_m[0], bus.btn_in};
      prs_m  = 1'b0;
      rel_m  = 1'b0;
      if (seen_m != lvl_m) run_m++;
      else                 run_m = 0;
      if (run_m == D + 1) begin
        lvl_m = ~lvl_m;
        run_m = 0;
        if (lvl_m) prs_m = 1'b1;
        else       rel_m = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en     = 1'b0;
  logic prev_pulse = 1'b0;
  int   last_kind  = 0;   // 0 none since reset, 1 press, 2 release
  int   npress     = 0;
  int   nrel       = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("level",   int'(bus.btn_level),   int'(lvl_m));
      check("press",   int'(bus.btn_press),   int'(prs_m));
      check("release", int'(bus.btn_release), int'(rel_m));
      check("pulse_both", int'(bus.btn_press & bus.btn_release), 0);
      check("pulse_back_to_back",
            int'((bus.btn_press | bus.btn_release) & prev_pulse), 0);
      if (bus.btn_press) begin
        check("press_after_press", int'(last_kind == 1), 0);
        last_kind = 1;
        npress++;
      end
      if (bus.btn_release) begin
        check("release_after_release", int'(last_kind == 2), 0);
        last_kind = 2;
        nrel++;
      end
      prev_pulse = bus.btn_press | bus.btn_release;
      if (!rst) last_kind = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input int lvl, input int prs, input int rel);
    check({name, "_level"},   int'(bus.btn_level),   lvl);
    check({name, "_press"},   int'(bus.btn_press),   prs);
    check({name, "_release"}, int'(bus.btn_release), rel);
  endtask

  int   np0;
  int   nr0;
  int   nseg;
  int   exp_changes;
  logic stable_v;
  logic new_v;
  logic v;

  initial begin
    rst        = 1'b1;
    bus.btn_in = 1'b0;
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    check_outs("reset", 0, 0, 0);
    tick(3);
    rst = 1'b1;

    // press from reset: pulse after the 7th edge (edge 6)
    bus.btn_in = 1'b1;
    tick(6);
    check_outs("press_edge5", 0, 0, 0);
    tick(1);
    check_outs("press_edge6", 1, 1, 0);
    tick(1);
    check_outs("press_edge7", 1, 0, 0);
    tick(5);
    check("press_count", npress, 1);

    // release from HIGH: same latency, no press
    np0 = npress;
    bus.btn_in = 1'b0;
    tick(6);
    check_outs("release_edge5", 1, 0, 0);
    tick(1);
    check_outs("release_edge6", 0, 0, 1);
    tick(1);
    check_outs("release_edge7", 0, 0, 0);
    tick(5);
    check("release_count", nrel, 1);
    check("release_no_press", npress - np0, 0);

    // toggling every 2 cycles never gets accepted
    np0 = npress;
    for (int i = 0; i < 10; i++) begin
      bus.btn_in = (i % 2 == 1);
      tick(2);
    end
    bus.btn_in = 1'b0;
    tick(10);
    check("toggle_no_press", npress - np0, 0);
    check("toggle_level", int'(bus.btn_level), 0);

    // reset mid-debounce with input held high: fresh full debounce
    bus.btn_in = 1'b1;
    tick(5);
    rst = 1'b0;
    #1;
    check_outs("midreset", 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    np0 = npress;
    tick(6);
    check_outs("rearm_edge5", 0, 0, 0);
    tick(1);
    check_outs("rearm_edge6", 1, 1, 0);
    tick(10);
    check("rearm_press_count", npress - np0, 1);

    // reset while HIGH drops the level without a release pulse
    nr0 = nrel;
    np0 = npress;
    bus.btn_in = 1'b0;
    rst = 1'b0;
    #1;
    check_outs("high_reset", 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(15);
    check("high_reset_no_release", nrel - nr0, 0);
    check("high_reset_no_press", npress - np0, 0);

    // 3-cycle low glitch while HIGH is rejected
    bus.btn_in = 1'b1;
    tick(10);
    check("glitch_pre_level", int'(bus.btn_level), 1);
    nr0 = nrel;
    bus.btn_in = 1'b0;
    tick(3);
    bus.btn_in = 1'b1;
    tick(10);
    check("glitch_no_release", nrel - nr0, 0);
    check("glitch_level", int'(bus.btn_level), 1);

    // random short bounce bursts between long stable periods
    stable_v    = 1'b1;
    exp_changes = 0;
    np0         = npress;
    nr0         = nrel;
    for (int it = 0; it < 30; it++) begin
      nseg = $urandom_range(1, 4);
      v    = ~stable_v;
      for (int s = 0; s < nseg; s++) begin
        bus.btn_in = v;
        tick($urandom_range(1, 3));
        v = ~v;
      end
      new_v = 1'($urandom_range(0, 1));
      if (new_v != stable_v) exp_changes++;
      stable_v   = new_v;
      bus.btn_in = stable_v;
      tick($urandom_range(8, 15));
      check("rand_level", int'(bus.btn_level), int'(stable_v));
    end
    check("rand_pulse_count", (npress - np0) + (nrel - nr0), exp_changes);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, sets the number of consecutive stable synchronized samples required to accept an edge (20 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 20, is the debounce counter width and SHALL be large enough to hold DEBOUNCE_CYCLES-1; DEBOUNCE_CYCLES SHALL be at least 2.
REQ-003 Port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous reset, active-low; rst=0 resets the block immediately, without waiting for clk.
REQ-005 Port btn_in, input, 1 bit: raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-006 Port btn_level, output, 1 bit: debounced button level, registered; this is the enable that drives the downstream 500 ms refresh counter.
REQ-007 Port btn_press, output, 1 bit: registered one-clock pulse marking an accepted press.
REQ-008 Port btn_release, output, 1 bit: registered one-clock pulse marking an accepted release.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer (s1, then s2) before any other logic uses it; btn_s denotes the s2 output.
REQ-010 The FSM SHALL have exactly four states: IDLE (level 0), ARM_ON, HIGH (level 1) and ARM_OFF.
REQ-011 In IDLE, btn_s=1 SHALL move the FSM to ARM_ON with cnt=0; btn_s=0 SHALL keep it in IDLE.
REQ-012 In ARM_ON, btn_s=0 SHALL return the FSM to IDLE with cnt cleared and no pulse (glitch reject).
REQ-013 In ARM_ON with btn_s=1 and cnt≠DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-014 In ARM_ON with btn_s=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL enter HIGH, set btn_level=1, assert btn_press for exactly one cycle, and clear cnt.
REQ-015 In HIGH, btn_s=0 SHALL move the FSM to ARM_OFF with cnt=0; btn_s=1 SHALL keep it in HIGH.
REQ-016 ARM_OFF SHALL mirror ARM_ON with polarities swapped: btn_s=1 returns to HIGH with no pulse; DEBOUNCE_CYCLES consecutive btn_s=0 samples enter IDLE, set btn_level=0 and pulse btn_release for one cycle.
REQ-017 Latency: with btn_in stable from before rising edge 0, btn_press and the new btn_level SHALL be visible after rising edge DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges in total; release latency SHALL be identical.
REQ-018 btn_level SHALL change only on the edge that emits the matching pulse, so btn_level never toggles without a press or release pulse.
REQ-019 btn_press and btn_release SHALL never be asserted in the same cycle, nor in two consecutive cycles.
REQ-020 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-021 In IDLE and HIGH, cnt SHALL hold at 0.
REQ-022 Every output SHALL come directly from a flip-flop, with no combinational path from btn_in.

Reset
REQ-023 While rst=0, s1, s2, cnt, btn_level, btn_press and btn_release SHALL all be 0 and the state SHALL be IDLE.
REQ-024 Asserting rst mid-debounce or in HIGH SHALL abort the operation immediately; any pulse in flight is lost and no release pulse is emitted.
REQ-025 If btn_in is held at 1 across reset release, it SHALL be treated as a fresh press: the full debounce runs and btn_press is emitted.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-026 Reset then btn_in=1 held steady -> btn_press is a single 1-cycle pulse after edge 6, and btn_level=1 from that cycle onward.
REQ-027 btn_in 0→1→0→1 toggling every 2 cycles for 20 cycles, then 0 -> no btn_press, and btn_level stays 0.
REQ-028 From HIGH, btn_in=0 held -> btn_release is a single pulse after edge 6, btn_level=0, and there is no btn_press.
REQ-029 btn_in=1 for 5 cycles (FSM in ARM_ON, cnt=2), then rst=0 for 1 cycle while btn_in stays 1 -> all outputs 0 immediately, then a full 6-edge debounce after rst=1 ends in exactly one btn_press.
REQ-030 In HIGH, a 3-cycle low glitch on btn_in -> FSM returns to HIGH, no btn_release, and btn_level stays 1 throughout.
REQ-031 Random bounce bursts shorter than 4 cycles mixed with long stable periods -> a scoreboard confirms that press and release pulses alternate, one per stable level change, and btn_level matches a reference model.
